// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares one single-port RAM (registered read, one cycle of latency) between
// the instruction-fetch port (read-only) and the load/store port
// (read/write). One transaction is in flight at a time, and each one walks a
// fixed four-cycle sequence. Read data and a one-cycle ack go back to the
// port that won the grant.
//
// Build option:
//   RAM_ARB_RR_EN  defined   -> ties go round-robin (the port not granted
//                               last wins; the first tie after reset goes
//                               to fetch)
//                  undefined -> fixed priority (data wins every tie); the
//                               round-robin pointer is not built
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//
// Ports:
//   clk       rising-edge clock, shared with the RAM
//   reset     synchronous, active-high
//   if_req    fetch request, held with if_addr until if_ack
//   if_addr   fetch address
//   if_ack    one-cycle completion pulse to fetch
//   if_rdata  fetched data, valid while if_ack = 1
//   d_req     data request, held with d_we/d_addr/d_wdata until d_ack
//   d_we      1 = write, 0 = read
//   d_addr    data address
//   d_wdata   write data
//   d_ack     one-cycle completion pulse to the data port
//   d_rdata   read data (for a write, the old RAM contents), valid while d_ack = 1
//   ram_addr  RAM address
//   ram_data  RAM write data
//   ram_we    RAM write enable
//   ram_q     RAM registered read data
//   busy      high in every state except IDLE
//   owner     port of the current or last grant (0 = fetch, 1 = data)
//
// Every output comes straight from a flop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner's request
// ACCESS  | address/we presented to the RAM; write commits at the edge
// CAPTURE | ram_we forced low; ram_q valid and registered at the edge
// RESP    | owner's ack high for this one cycle; requests ignored

module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic grant_any;
  logic grant_d;

  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_nxt;
  logic              ram_we_nxt;
  logic              if_ack_nxt;
  logic              d_ack_nxt;
  logic [DATA_W-1:0] if_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_nxt;
  logic              busy_nxt;
  logic              owner_nxt;

`ifdef RAM_ARB_RR_EN
  // 1 when the most recent grant went to the data port.
  logic last_d;
`endif

  // Arbitration. A lone requester always wins; only a tie uses the policy.
  always_comb begin
    grant_any = if_req | d_req;
`ifdef RAM_ARB_RR_EN
    if (if_req && d_req) begin
      grant_d = ~last_d;
    end else begin
      grant_d = d_req;
    end
`else
    grant_d = d_req;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Only the exit from IDLE depends on the inputs.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = grant_any ? S_ACCESS : S_IDLE;
      S_ACCESS:  state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the output flops. Acks default low, so
  // one set in CAPTURE is high for the RESP cycle only.
  always_comb begin
    ram_addr_nxt = ram_addr;
    ram_data_nxt = ram_data;
    ram_we_nxt   = ram_we;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    owner_nxt    = owner;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    busy_nxt     = (state_nxt != S_IDLE);

    case (state)
      S_IDLE: begin
        if (grant_any) begin
          owner_nxt = grant_d;
          if (grant_d) begin
            ram_addr_nxt = d_addr;
            ram_data_nxt = d_wdata;
            ram_we_nxt   = d_we;
          end else begin
            ram_addr_nxt = if_addr;
            ram_data_nxt = '0;
            ram_we_nxt   = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        // The write commits at the edge that ends ACCESS, so it must not
        // repeat in CAPTURE.
        ram_we_nxt = 1'b0;
      end
      S_CAPTURE: begin
        // ram_q holds the pre-write contents for writes (read-before-write).
        if (owner) begin
          d_rdata_nxt = ram_q;
          d_ack_nxt   = 1'b1;
        end else begin
          if_rdata_nxt = ram_q;
          if_ack_nxt   = 1'b1;
        end
      end
      S_RESP: begin
      end
      default: begin
      end
    endcase
  end

  // Output registers. A reset during ACCESS abandons the transaction; the
  // write may already have committed in the RAM, which has no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
    end else begin
      ram_addr <= ram_addr_nxt;
      ram_data <= ram_data_nxt;
      ram_we   <= ram_we_nxt;
      if_ack   <= if_ack_nxt;
      d_ack    <= d_ack_nxt;
      if_rdata <= if_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
      busy     <= busy_nxt;
      owner    <= owner_nxt;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Round-robin pointer. It resets to "data last" so the first tie goes to
  // fetch. It follows every grant, including uncontested ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b1;
    end else if (state == S_IDLE && grant_any) begin
      last_d <= grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_ack;
  logic [7:0] if_rdata;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic [7:0] ram_q;
  logic       busy;
  logic       owner;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic       mem_load;
  logic [7:0] mem [256];
  logic [7:0] shadow [256];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy), .owner(owner)
  );

  // Single-port RAM with registered read, no reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 2);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       port;   // 0 = fetch, 1 = data
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 15));
  endfunction

  // One isolated transaction from IDLE; checks latency, data, busy and we.
  task automatic run_txn(input vec_t v, input int idx);
    int got;
    int busy_n;
    int we_n;
    int lat;
    got = 0; busy_n = 0; we_n = 0; lat = 0;
    @(negedge clk);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 8 && got == 0; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (ram_we) we_n++;
      if (k == 1) chk($sformatf("vec%0d ram_addr", idx), 32'(ram_addr), 32'(v.addr));
      if (if_ack || d_ack) begin
        got = 1;
        lat = k;
        chk($sformatf("vec%0d owner ack", idx), 32'(v.port ? d_ack : if_ack), 1);
        chk($sformatf("vec%0d other ack", idx), 32'(v.port ? if_ack : d_ack), 0);
        chk($sformatf("vec%0d rdata", idx), 32'(v.port ? d_rdata : if_rdata), 32'(v.exp_rdata));
      end
    end
    chk($sformatf("vec%0d ack seen", idx), 32'(got), 1);
    chk($sformatf("vec%0d latency", idx), 32'(lat), 3);
    chk($sformatf("vec%0d busy cycles", idx), 32'(busy_n), 3);
    chk($sformatf("vec%0d ram_we cycles", idx), 32'(we_n), 32'(v.we));
    if_req = 1'b0;
    d_req  = 1'b0;
    if (v.we) shadow[v.addr] = v.wdata;
  endtask

  initial begin
    vec_t vecs[8];
    int   exp_seq[5];
    int   acks, first_k, second_k, extra, n_ack, last_c;
    bit         g_valid, g_port, g_we;
    int         g_cyc;
    logic [7:0] g_addr, g_wdata, g_data, e_if_rd, e_d_rd;
`ifdef RAM_ARB_RR_EN
    bit rr_last;
    exp_seq = '{0, 1, 0, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1, 0};
`endif

    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h02, wdata: 8'h00, exp_rdata: 8'h04};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h10, wdata: 8'hA5, exp_rdata: 8'h20};
    vecs[2] = '{port: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[3] = '{port: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hFE};
    vecs[5] = '{port: 1'b1, we: 1'b1, addr: 8'h00, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[6] = '{port: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[7] = '{port: 1'b1, we: 1'b0, addr: 8'h02, wdata: 8'h00, exp_rdata: 8'h04};

    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 2);

    reset = 1'b1; mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_load = 1'b0;

    // Reset values.
    chk("reset busy", 32'(busy), 0);
    chk("reset if_ack", 32'(if_ack), 0);
    chk("reset d_ack", 32'(d_ack), 0);
    chk("reset ram_we", 32'(ram_we), 0);
    chk("reset ram_addr", 32'(ram_addr), 0);
    chk("reset ram_data", 32'(ram_data), 0);
    chk("reset owner", 32'(owner), 0);
    chk("reset if_rdata", 32'(if_rdata), 0);
    chk("reset d_rdata", 32'(d_rdata), 0);

    // Table of isolated transactions.
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // d_req held across d_ack: back-to-back transactions, one ack each.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    acks = 0; first_k = 0; second_k = 0; extra = 0;
    for (int k = 1; k <= 12 && acks < 2; k++) begin
      @(negedge clk);
      if (d_ack) begin
        acks++;
        chk("hold d_rdata", 32'(d_rdata), 32'(shadow[8'h02]));
        if (acks == 1) first_k = k;
        else begin second_k = k; d_req = 1'b0; end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_ack || if_ack || busy) extra++;
    end
    chk("hold ack count", 32'(acks), 2);
    chk("hold first ack", 32'(first_k), 3);
    chk("hold second ack", 32'(second_k), 7);
    chk("hold no trailing activity", 32'(extra), 0);

    // Reset in the ACCESS cycle of a write.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    @(negedge clk);
    chk("rst-access ram_we", 32'(ram_we), 1);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    shadow[8'h20] = 8'h3C;
    chk("rst-access ram commit", 32'(mem[8'h20]), 32'h3C);
    chk("rst-access busy", 32'(busy), 0);
    chk("rst-access d_ack", 32'(d_ack), 0);
    chk("rst-access ram_we off", 32'(ram_we), 0);
    chk("rst-access ram_addr", 32'(ram_addr), 0);
    chk("rst-access ram_data", 32'(ram_data), 0);
    chk("rst-access owner", 32'(owner), 0);
    chk("rst-access d_rdata", 32'(d_rdata), 0);
    chk("rst-access if_rdata", 32'(if_rdata), 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_ack || if_ack) extra++;
    end
    chk("rst-access no ack", 32'(extra), 0);

    // Both ports request continuously; d_req drops after the 4th ack.
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h02; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    n_ack = 0; last_c = 0;
    for (int k = 0; k < 40 && n_ack < 5; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        chk("tie single ack", 32'(if_ack & d_ack), 0);
        chk($sformatf("tie grant%0d port", n_ack), 32'(d_ack), 32'(exp_seq[n_ack]));
        if (d_ack) chk("tie d_rdata", 32'(d_rdata), 32'(shadow[8'h10]));
        else       chk("tie if_rdata", 32'(if_rdata), 32'(shadow[8'h02]));
        if (n_ack > 0) chk("tie ack spacing", 32'(cyc - last_c), 4);
        last_c = cyc;
        n_ack++;
        if (n_ack == 4) d_req = 1'b0;
        if (n_ack == 5) if_req = 1'b0;
      end
    end
    chk("tie ack count", 32'(n_ack), 5);
    if_req = 1'b0; d_req = 1'b0;

    // Randomized traffic against a transaction-timeline reference model.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    g_valid = 1'b0; g_cyc = 0; g_port = 1'b0; g_we = 1'b0;
    g_addr = '0; g_wdata = '0; g_data = '0; e_if_rd = '0; e_d_rd = '0;
`ifdef RAM_ARB_RR_EN
    rr_last = 1'b1;
`endif
    for (int c = 0; c < 800; c++) begin
      int rel;
      bit in_txn, ack_now, w;
      rel = g_valid ? c - g_cyc : 99;
      in_txn  = (rel >= 1 && rel <= 3);
      ack_now = (rel == 3);
      if (ack_now) begin
        if (g_port) e_d_rd = g_data;
        else        e_if_rd = g_data;
      end
      chk("rnd busy", 32'(busy), 32'(in_txn));
      chk("rnd if_ack", 32'(if_ack), 32'(ack_now && !g_port));
      chk("rnd d_ack", 32'(d_ack), 32'(ack_now && g_port));
      chk("rnd if_rdata", 32'(if_rdata), 32'(e_if_rd));
      chk("rnd d_rdata", 32'(d_rdata), 32'(e_d_rd));
      chk("rnd owner", 32'(owner), 32'(g_valid && g_port));
      chk("rnd ram_we", 32'(ram_we), 32'(rel == 1 && g_we));
      chk("rnd ram_addr", 32'(ram_addr), 32'(g_addr));
      chk("rnd ram_data", 32'(ram_data), 32'(g_wdata));

      // Requesters: hold until ack, then either chain a new request or drop.
      if (if_req) begin
        if (ack_now && !g_port) begin
          if ($urandom_range(0, 1) == 1) if_addr = rnd_addr();
          else if_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (d_req) begin
        if (ack_now && g_port) begin
          if ($urandom_range(0, 1) == 1) begin
            d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = 8'($urandom);
          end else d_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = 8'($urandom);
      end

      // A new grant is possible once the previous transaction's four cycles are over.
      if (rel >= 4 && (if_req || d_req)) begin
        if (if_req && d_req) begin
`ifdef RAM_ARB_RR_EN
          w = !rr_last;
`else
          w = 1'b1;
`endif
        end else w = d_req;
`ifdef RAM_ARB_RR_EN
        rr_last = w;
`endif
        g_valid = 1'b1;
        g_cyc   = c;
        g_port  = w;
        g_addr  = w ? d_addr : if_addr;
        g_we    = w && d_we;
        g_wdata = w ? d_wdata : 8'h00;
        g_data  = shadow[g_addr];
        if (g_we) shadow[g_addr] = g_wdata;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer sharing the CPU's single-port 256×8 program/data RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write). Serializes one transaction at a time through a fixed 4-cycle state machine and absorbs the RAM's one-cycle registered read latency. Returns read data and a one-cycle `ack` to the winning requester. Sits between the control unit's fetch/execute logic and the RAM instance.

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.

Clock is `clk`. Reset is `reset`, synchronous and active-high.

- `clk` input 1: rising-edge clock, shared with the RAM.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request; held with `if_addr` stable until `if_ack`.
- `if_addr` input ADDR_W: fetch address.
- `if_ack` output 1: one-cycle completion pulse to fetch.
- `if_rdata` output DATA_W: fetched byte; valid while `if_ack`=1.
- `d_req` input 1: data request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_ack`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: write data.
- `d_ack` output 1: one-cycle completion pulse to the data port.
- `d_rdata` output DATA_W: read data; valid while `d_ack`=1.
- `ram_addr` output ADDR_W: to RAM `addr`.
- `ram_data` output DATA_W: to RAM `data`.
- `ram_we` output 1: to RAM `we`.
- `ram_q` input DATA_W: from RAM `q`.
- `busy` output 1: high in every state except IDLE.
- `owner` output 1: port of the current or last grant; 0 = fetch, 1 = data.

## Operation
- States: IDLE → ACCESS → CAPTURE → RESP → IDLE. Every transition is unconditional except the exit from IDLE.
- IDLE: if neither request is high, stay in IDLE. Otherwise pick a winner, latch its addr/we/wdata into `ram_addr`/`ram_we`/`ram_data`, set `owner`, and go to ACCESS. Fetch latches `ram_we`=0 and `ram_data`=0.
- ACCESS: `ram_addr` and `ram_we` are presented to the RAM. At the closing edge the RAM writes (if `ram_we`=1) and loads `q`.
- CAPTURE: `ram_we` is forced to 0. `ram_q` is now valid. At the closing edge, `ram_q` is registered into the owner's `*_rdata` and the owner's `*_ack` is set.
- RESP: the owner's `ack`=1 for exactly this cycle. Requests are not sampled in RESP. At the closing edge `ack` clears and the state goes to IDLE.
- Requesters drop or change `req` on the edge that ends RESP. A request still high in IDLE is treated as a new transaction.
- Writes return the pre-write RAM contents on `d_rdata` (read-before-write). Software must ignore this value.
- A single active requester is always granted.
- Tie-breaking when both requests are high in IDLE is set by the Configuration section below.
- The non-owner's `*_rdata` holds its previous value. Its `ack` stays 0.
- Requests arriving while `busy`=1 wait. They are never dropped.

## Timing
- Request-to-ack latency is 3 cycles: `req` sampled at edge E0, `ack` high in the cycle after E2. Throughput is one transaction per 4 cycles.
- All outputs are registered; there is no combinational path from input to output.
- Reset values: state IDLE, `ram_addr`=0, `ram_data`=0, `ram_we`=0, `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0, `busy`=0, `owner`=0, round-robin pointer = "data last".
- Reset while in ACCESS: a write that was presented still commits at that edge, because the RAM has no reset. The transaction is abandoned and no `ack` is issued.
- Reset in CAPTURE or RESP: any pending or current `ack` is cleared and the state goes to IDLE.
- Address wrap-around is not applicable; the full ADDR_W range is accepted with no bounds check.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin. On a tie, grant the port not granted last. After reset the first tie goes to fetch.
- `RAM_ARB_RR_EN` undefined: fixed priority; the data port wins every tie. The pointer logic is compiled out.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset, then fetch `if_addr`=0x02 with RAM[2]=0x04 -> `if_ack`=1 exactly 3 cycles after the request is sampled; `if_rdata`=0x04; `busy` high for 3 cycles.
- Data write `d_addr`=0x10, `d_wdata`=0xA5, then data read of 0x10 -> `ram_we` high for exactly 1 cycle; the read returns `d_rdata`=0xA5; the write's `d_rdata` equals the old RAM[0x10].
- Both ports request continuously with `RAM_ARB_RR_EN` defined -> grants alternate fetch, data, fetch, data; an `ack` pulse every 4 cycles.
- Same stimulus with the macro undefined -> four consecutive data grants while `d_req` stays high; fetch granted only after `d_req` drops.
- `d_req` held with no drop after `d_ack` -> a second transaction starts in the following IDLE cycle; no duplicate `ack` within a transaction.
- `reset` asserted in the ACCESS cycle of write 0x20←0x3C -> RAM[0x20]=0x3C afterwards; no `d_ack`; all outputs at reset values the next cycle.
